// File: rtl/smp8_pkg.sv
// smp8_pkg: shared types and constants for the SMP8 data-memory arbiter
package smp8_pkg;
  typedef enum logic {ARB = 1'b0, HLOCK = 1'b1} arb_state_t;
  localparam int SMP8_DMEM_AW = 4;
  localparam int SMP8_DW = 8;
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_HOST = 1'b1;
endpackage

// File: rtl/smp8_dmem_arbiter_sat_counter.sv
// smp8_sat_counter: saturating up-counter; clr restarts at 0, or at 1 when inc is also high
module smp8_sat_counter #(
  parameter int W = 4,
  parameter int LIMIT = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (clr) cnt <= inc ? W'(1) : '0;
    else if (inc && cnt != W'(LIMIT)) cnt <= cnt + W'(1);
endmodule

// File: rtl/smp8_dmem_arbiter.sv
// smp8_dmem_arbiter: CPU/host arbiter for the SMP8 16x8 data memory port.
// SMP8_ARB_ROUND_ROBIN_EN selects alternating priority instead of CPU priority with starvation escape.
module smp8_dmem_arbiter
  import smp8_pkg::*;
#(
  parameter int HOST_MAX_WAIT = 4,
  parameter int LOCK_MAX = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [SMP8_DMEM_AW-1:0] cpu_addr,
  input  logic [SMP8_DW-1:0]      cpu_wdata,
  output logic                    cpu_gnt,
  output logic                    cpu_stall,
  input  logic                    host_req,
  input  logic                    host_we,
  input  logic [SMP8_DMEM_AW-1:0] host_addr,
  input  logic [SMP8_DW-1:0]      host_wdata,
  input  logic                    host_lock,
  output logic                    host_gnt,
  output logic [SMP8_DW-1:0]      rdata,
  output logic                    rvalid,
  output logic                    rsrc,
  output logic                    mem_we,
  output logic [SMP8_DMEM_AW-1:0] mem_addr,
  output logic [SMP8_DW-1:0]      mem_wd,
  input  logic [SMP8_DW-1:0]      mem_rd
);
  arb_state_t state, state_nx;
  logic [3:0] lock_cnt, lock_nx;
  logic cpu_pri, host_turn, grant, win_we, max_hit;

`ifdef SMP8_ARB_ROUND_ROBIN_EN
  logic rr_host;
  always_ff @(posedge clk or posedge reset)
    if (reset) rr_host <= 1'b0;
    else if (state == ARB && cpu_req && host_req) rr_host <= cpu_gnt;
  assign host_turn = rr_host;
`else
  logic [3:0] wait_cnt;
  smp8_sat_counter #(.W(4), .LIMIT(HOST_MAX_WAIT)) u_wait (
    .clk(clk), .reset(reset),
    .clr(~host_req | host_gnt), .inc(host_req & ~host_gnt),
    .cnt(wait_cnt)
  );
  assign host_turn = (wait_cnt == 4'(HOST_MAX_WAIT));
`endif

  // lock_cnt is held at 0 in ARB and loads 1 on the grant that opens a burst
  smp8_sat_counter #(.W(4), .LIMIT(LOCK_MAX)) u_lock (
    .clk(clk), .reset(reset),
    .clr(state == ARB), .inc(host_gnt & host_lock),
    .cnt(lock_cnt)
  );

  // grants are suppressed during reset so an access coinciding with reset is dropped
  always_comb begin
    host_gnt = ~reset & host_req & ((state == HLOCK) | ~cpu_req | (~cpu_pri & host_turn));
    cpu_gnt = ~reset & cpu_req & ~host_gnt;
    grant = cpu_gnt | host_gnt;
    win_we = host_gnt ? host_we : cpu_we;
    mem_we = win_we & grant;
    mem_addr = host_gnt ? host_addr : cpu_gnt ? cpu_addr : '0;
    mem_wd = host_gnt ? host_wdata : cpu_gnt ? cpu_wdata : '0;
    lock_nx = (state == HLOCK) ? lock_cnt + 4'd1 : 4'd1;
    max_hit = host_gnt & host_lock & (lock_nx == 4'(LOCK_MAX));
    state_nx = (host_gnt & host_lock & ~max_hit) ? HLOCK : ARB;
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= ARB;
      cpu_pri <= 1'b0;
      rdata <= '0;
      rvalid <= 1'b0;
      rsrc <= OWN_CPU;
    end else begin
      state <= state_nx;
      cpu_pri <= max_hit;
      rvalid <= grant & ~win_we;
      if (grant & ~win_we) begin
        rdata <= mem_rd;
        rsrc <= host_gnt ? OWN_HOST : OWN_CPU;
      end
    end
endmodule

// File: tb/tb_smp8_dmem_arbiter.sv
// tb_smp8_dmem_arbiter: directed plus random checks of smp8_dmem_arbiter against a behavioural model
module tb_smp8_dmem_arbiter;
  localparam int HMW = 4;
  localparam int LMX = 8;
`ifdef SMP8_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0, reset;
  logic cpu_req, cpu_we, host_req, host_we, host_lock;
  logic [3:0] cpu_addr, host_addr, mem_addr;
  logic [7:0] cpu_wdata, host_wdata, rdata, mem_wd, mem_rd;
  logic cpu_gnt, cpu_stall, host_gnt, rvalid, rsrc, mem_we;
  logic [7:0] ram [16];

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wd;
  assign mem_rd = ram[mem_addr];

  smp8_dmem_arbiter #(.HOST_MAX_WAIT(HMW), .LOCK_MAX(LMX)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_lock(host_lock), .host_gnt(host_gnt),
    .rdata(rdata), .rvalid(rvalid), .rsrc(rsrc),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  int total = 0, bad = 0;
  int m_burst, m_wait;
  bit m_cpu_first, m_rr_host, m_rv, m_rs, e_cg, e_hg;
  logic [7:0] m_rd;
  logic [7:0] exp_ram [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_burst = 0; m_wait = 0; m_cpu_first = 0; m_rr_host = 0;
    m_rv = 0; m_rd = 8'd0; m_rs = 0;
  endtask

  // one clock: predict winner from the rules, compare, advance model, step past the edge
  task automatic cyc();
    logic [3:0] a;
    bit w;
    int n;
    #3;
    if (reset) model_reset();
    if (reset) e_hg = 0;
    else if (m_burst > 0 || !cpu_req) e_hg = host_req;
    else if (m_cpu_first) e_hg = 0;
    else e_hg = host_req && (RR ? m_rr_host : (m_wait >= HMW));
    e_cg = !reset && cpu_req && !e_hg;
    a = e_hg ? host_addr : e_cg ? cpu_addr : 4'd0;
    w = e_hg ? host_we : cpu_we;
    chk("cpu_gnt", cpu_gnt, e_cg);
    chk("host_gnt", host_gnt, e_hg);
    chk("cpu_stall", cpu_stall, cpu_req && !e_cg);
    chk("mem_addr", mem_addr, a);
    chk("mem_we", mem_we, (e_cg || e_hg) && w);
    chk("rvalid", rvalid, m_rv);
    chk("rdata", rdata, m_rd);
    chk("rsrc", rsrc, m_rs);
    if (!reset) begin
      if ((e_cg || e_hg) && !w) begin m_rv = 1; m_rd = exp_ram[a]; m_rs = e_hg; end
      else m_rv = 0;
      if ((e_cg || e_hg) && w) exp_ram[a] = e_hg ? host_wdata : cpu_wdata;
      if (m_burst == 0 && cpu_req && host_req) m_rr_host = e_cg;
      m_wait = (host_req && !e_hg) ? ((m_wait < HMW) ? m_wait + 1 : HMW) : 0;
      m_cpu_first = 0;
      if (e_hg && host_lock) begin
        n = m_burst + 1;
        if (n == LMX) begin m_burst = 0; m_cpu_first = 1; end
        else m_burst = n;
      end else m_burst = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hi;
    bit cpu_post;
    logic [14:0] seq;
    reset = 1; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0; host_lock = 0;
    for (int i = 0; i < 16; i++) begin ram[i] = 8'd0; exp_ram[i] = 8'd0; end
    ram[0] = 8'd55; exp_ram[0] = 8'd55; ram[1] = 8'd29; exp_ram[1] = 8'd29;
    model_reset();
    #1;
    chk("rst_rdata", rdata, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rsrc", rsrc, 0);
    chk("rst_mem_we", mem_we, 0);
    cyc(); cyc();

    // CPU read of addr 0 right after reset release
    reset = 0; cpu_req = 1; cpu_addr = 0;
    #1 chk("rel_cpu_gnt", cpu_gnt, 1);
    cyc();
    cpu_req = 0;
    #1 chk("rel_rvalid", rvalid, 1);
    chk("rel_rdata", rdata, 55);
    chk("rel_rsrc", rsrc, 0);
    cyc();

    // contention: CPU reads addr 5, host reads addr 1
    cpu_req = 1; cpu_addr = 5; host_req = 1; host_addr = 1;
    for (int i = 1; i <= 5; i++) begin
      #1;
      if (!RR) begin
        chk("cont_cpu_gnt", cpu_gnt, i < 5);
        chk("cont_host_gnt", host_gnt, i == 5);
        chk("cont_stall", cpu_stall, i == 5);
      end
      cyc();
    end
    cpu_req = 0; host_req = 0;
    if (!RR) begin
      #1 chk("cont_rdata", rdata, 29);
      chk("cont_rsrc", rsrc, 1);
    end
    cyc();

    // locked host burst of 10 writes against a busy CPU
    hi = 0; cpu_post = 0; seq = '0;
    host_lock = 1; host_we = 1; cpu_addr = 9;
    for (int c = 0; c < 40 && hi < 10; c++) begin
      host_req = 1; host_addr = 4'(hi); host_wdata = 8'(8'hA0 + hi);
      cpu_req = !(cpu_post && hi == 8);
      #1;
      if (cpu_gnt || host_gnt) seq = {seq[13:0], host_gnt};
      if (cpu_gnt && hi == 8) cpu_post = 1;
      if (host_gnt) hi++;
      cyc();
    end
    chk("burst_done", hi, 10);
    if (!RR) chk("burst_seq", seq, 15'b000011111111011);
    host_req = 0; host_lock = 0; host_we = 0; cpu_req = 0;
    cyc();
    for (int i = 0; i < 8; i++) chk("burst_ram", ram[i], 8'hA0 + i);

    // CPU write then read-back
    cpu_req = 1; cpu_we = 1; cpu_addr = 2; cpu_wdata = 8'd114;
    #1 chk("wr_gnt", cpu_gnt, 1);
    cyc();
    cpu_we = 0;
    cyc();
    cpu_req = 0;
    #1 chk("wr_rd_rvalid", rvalid, 1);
    chk("wr_rd_rdata", rdata, 114);
    cyc();

    // reset in the middle of a locked host read burst (lock_cnt reaches 3)
    host_req = 1; host_lock = 1; host_we = 0; host_addr = 2;
    repeat (3) cyc();
    cpu_req = 1; reset = 1;
    #1 chk("mid_host_gnt", host_gnt, 0);
    chk("mid_rvalid", rvalid, 0);
    chk("mid_rdata", rdata, 0);
    chk("mid_rsrc", rsrc, 0);
    chk("mid_mem_we", mem_we, 0);
    cyc();
    reset = 0; host_lock = 0;
    #1 chk("post_rst_cpu_gnt", cpu_gnt, 1);
    chk("post_rst_host_gnt", host_gnt, 0);
    cyc();
    if (RR)
      for (int i = 1; i <= 5; i++) begin
        #1 chk("rr_host_gnt", host_gnt, i % 2);
        cyc();
      end
    cpu_req = 0; host_req = 0;
    cyc();

    // random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      cpu_req = ($urandom_range(0, 3) != 0);
      cpu_we = 1'($urandom); cpu_addr = 4'($urandom); cpu_wdata = 8'($urandom);
      host_req = ($urandom_range(0, 2) != 0);
      host_we = 1'($urandom); host_addr = 4'($urandom); host_wdata = 8'($urandom);
      host_lock = ($urandom_range(0, 3) != 0);
      cyc();
    end
    reset = 0; cpu_req = 0; host_req = 0;
    cyc();
    for (int i = 0; i < 16; i++) chk("final_ram", ram[i], exp_ram[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
